// File: rtl/mem_if_mc.sv
// mem_if_mc: unified instruction/data memory interface for the multi-cycle
// MIPS datapath. Request capture, IDLE/WAIT/ACCESS handshake FSM, byte-lane
// stores, IR/MDR capture with lb/lbu/lh/lhu/lw extension.
// Optional feature macro: MEMIF_MISALIGN_CHECK_EN (trap misaligned accesses
// instead of silently forcing natural alignment).
module mem_if_mc #(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] IR_RESET    = 32'hCCCC_CCCC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic [31:0] data_addr,
    input  logic        IorD,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] wd,
    input  logic        IRWrite,
    output logic        busy,
    output logic        done,
    output logic        misalign,
    output logic [31:0] now_Instr,
    output logic [31:0] mdr
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;

    logic [31:0]   sel_addr;
    logic [AW+1:0] req_addr;
    logic          req_mis;
    logic          unused_addr;

    logic [AW+1:0] addr_q;
    logic          we_q, lu_q, irw_q;
    logic [1:0]    size_q;
    logic [31:0]   wd_q;
    logic          acc_ok;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   rd_word;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   ld_val;

    assign sel_addr    = IorD ? data_addr : pc;
    // Bits above the array index are dropped, so addresses wrap.
    assign unused_addr = ^sel_addr[31:AW+2];

    // Address fed into the latch: raw when trapping, else naturally aligned
    always_comb begin
        req_addr = sel_addr[AW+1:0];
        req_mis  = 1'b0;
`ifdef MEMIF_MISALIGN_CHECK_EN
        req_mis = ((size == 2'b01) && sel_addr[0])
                | (size[1] && (sel_addr[1:0] != 2'b00))
                | (!IorD && (pc[1:0] != 2'b00));
`else
        if (size == 2'b01) req_addr[0] = 1'b0;
        else if (size[1])  req_addr[1:0] = 2'b00;
`endif
    end

`ifdef MEMIF_MISALIGN_CHECK_EN
    logic mis_q;

    // Trap flag travels with the accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      mis_q <= 1'b0;
        else if (state_q == S_IDLE && req) mis_q <= req_mis;
    end

    assign acc_ok   = !mis_q;
    assign misalign = (state_q == S_ACCESS) && mis_q;
`else
    assign acc_ok   = 1'b1;
    assign misalign = 1'b0;
`endif

    // Latch the request in IDLE; later input changes are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            we_q   <= 1'b0;
            size_q <= 2'b00;
            lu_q   <= 1'b0;
            wd_q   <= '0;
            irw_q  <= 1'b0;
        end else if (state_q == S_IDLE && req) begin
            addr_q <= req_addr;
            we_q   <= we;
            size_q <= size;
            lu_q   <= load_unsigned;
            wd_q   <= wd;
            irw_q  <= IRWrite;
        end
    end

    // FSM state, wait counter and registered busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= (state_d != S_IDLE);
        end
    end

    // Next state: WAIT is skipped entirely when no wait states are configured
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    cnt_d   = '0;
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'(WAIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ACCESS: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign done = (state_q == S_ACCESS);

    // Lane enables and replicated store data
    always_comb begin
        case (size_q)
            2'b00: begin
                be    = 4'b0001 << addr_q[1:0];
                wdata = {4{wd_q[7:0]}};
            end
            2'b01: begin
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata = {2{wd_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = wd_q;
            end
        endcase
    end

    // Array write on the ACCESS closing edge; contents survive reset
    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS && we_q && acc_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rd_word = mem[addr_q[AW+1:2]];

    // Lane select and extension for the MDR
    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        half_sel = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_q)
            2'b00:   ld_val = lu_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   ld_val = lu_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: ld_val = rd_word;
        endcase
    end

    // IR/MDR capture on a read's ACCESS closing edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now_Instr <= IR_RESET;
            mdr       <= '0;
        end else if (state_q == S_ACCESS && !we_q && acc_ok) begin
            mdr <= ld_val;
            if (irw_q) now_Instr <= rd_word;
        end
    end

endmodule

// File: tb/tb_mem_if_mc.sv
// Bench for mem_if_mc: three instances (WAIT 0 / DEPTH 16 WAIT 2 / WAIT 3),
// table-driven accesses with a queue of expected results, plus hand-written
// overlap and reset-abort sequences.
module tb_mem_if_mc;

`ifdef MEMIF_MISALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic [2:0]        rst_n;
    logic [2:0][31:0]  pc, data_addr, wd, now_instr, mdr;
    logic [2:0]        iord, req, we, lu, irw, busy, done, misalign;
    logic [2:0][1:0]   size;

    int checks   = 0;
    int failures = 0;
    int wcyc [3] = '{0, 2, 3};
    logic [31:0] mdl_mdr [3];
    logic [31:0] mdl_ir  [3];

    typedef struct {
        int          u;
        logic [31:0] mdr;
        logic [31:0] ir;
        logic        mis;
        int          lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        iord, we;
        logic [1:0]  sz;
        logic        lu, irw, mal;
        logic [31:0] addr, wd, exp;
    } vec_t;
    vec_t tbl [18];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_if_mc #(
            .DEPTH      (g == 1 ? 16 : 1024),
            .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 2 : 3)),
            .IR_RESET   (32'hCCCC_CCCC)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n[g]),
            .pc           (pc[g]),
            .data_addr    (data_addr[g]),
            .IorD         (iord[g]),
            .req          (req[g]),
            .we           (we[g]),
            .size         (size[g]),
            .load_unsigned(lu[g]),
            .wd           (wd[g]),
            .IRWrite      (irw[g]),
            .busy         (busy[g]),
            .done         (done[g]),
            .misalign     (misalign[g]),
            .now_Instr    (now_instr[g]),
            .mdr          (mdr[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input int u, input string tag);
        chk($sformatf("%s_busy%0d", tag, u), {31'd0, busy[u]}, 32'd0);
        chk($sformatf("%s_done%0d", tag, u), {31'd0, done[u]}, 32'd0);
        chk($sformatf("%s_mis%0d", tag, u), {31'd0, misalign[u]}, 32'd0);
        chk($sformatf("%s_ir%0d", tag, u), now_instr[u], mdl_ir[u]);
        chk($sformatf("%s_mdr%0d", tag, u), mdr[u], mdl_mdr[u]);
    endtask

    // One full access: drive, push expectation, wait for done, pop and compare
    task automatic access(input int u, input vec_t v, input string name);
        exp_t e, p;
        int   n;
        bit   got, busy_ok, mis_seen, trap;
        trap = CHK && v.mal;
        if (!v.we && !trap) begin
            mdl_mdr[u] = v.exp;
            if (v.irw) mdl_ir[u] = v.exp;
        end
        e = '{u, mdl_mdr[u], mdl_ir[u], trap, 1 + wcyc[u]};
        @(posedge clk); #1;
        iord[u] = v.iord; we[u] = v.we; size[u] = v.sz; lu[u] = v.lu;
        irw[u] = v.irw; wd[u] = v.wd;
        pc[u]        = v.iord ? 32'hFFFF_FFF3 : v.addr;
        data_addr[u] = v.iord ? v.addr : ~v.addr;
        req[u] = 1'b1;
        @(posedge clk); #1;
        req[u] = 1'b0;
        wd[u] = ~v.wd; data_addr[u] = 32'h0000_0BAD; size[u] = ~v.sz;
        sb.push_back(e);
        n = 0; got = 0; busy_ok = 1; mis_seen = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (!busy[u]) busy_ok = 0;
            if (done[u]) begin
                got = 1;
                mis_seen = misalign[u];
            end
        end
        p = sb.pop_front();
        chk({name, "_lat"}, n, p.lat);
        chk({name, "_busy"}, {31'd0, busy_ok}, 32'd1);
        chk({name, "_mis"}, {31'd0, mis_seen}, {31'd0, p.mis});
        @(posedge clk); #1;
        chk({name, "_mdr"}, mdr[p.u], p.mdr);
        chk({name, "_ir"}, now_instr[p.u], p.ir);
    endtask

    initial begin
        bit [7:0] dpat, bpat;
        vec_t v;
        rst_n = '0; req = '0; iord = '0; we = '0; lu = '0; irw = '0;
        size = '0; pc = '0; data_addr = '0; wd = '0;
        for (int u = 0; u < 3; u++) begin
            mdl_mdr[u] = 32'd0;
            mdl_ir[u]  = 32'hCCCC_CCCC;
        end

        //            iord we  sz    lu  irw mal  addr   wd             exp
        tbl[0]  = '{1'b1,1'b1,2'b10,1'b0,1'b0,1'b0,32'h10,32'h2008_0005,32'h0};
        tbl[1]  = '{1'b0,1'b0,2'b10,1'b0,1'b1,1'b0,32'h10,32'h0,        32'h2008_0005};
        tbl[2]  = '{1'b1,1'b1,2'b10,1'b0,1'b0,1'b0,32'h20,32'h1122_3344,32'h0};
        tbl[3]  = '{1'b1,1'b1,2'b00,1'b0,1'b0,1'b0,32'h21,32'h0000_00FF,32'h0};
        tbl[4]  = '{1'b1,1'b0,2'b10,1'b0,1'b0,1'b0,32'h20,32'h0,        32'h1122_FF44};
        tbl[5]  = '{1'b1,1'b0,2'b00,1'b0,1'b0,1'b0,32'h21,32'h0,        32'hFFFF_FFFF};
        tbl[6]  = '{1'b1,1'b0,2'b00,1'b1,1'b0,1'b0,32'h21,32'h0,        32'h0000_00FF};
        tbl[7]  = '{1'b1,1'b0,2'b01,1'b0,1'b0,1'b0,32'h22,32'h0,        32'h0000_1122};
        tbl[8]  = '{1'b1,1'b0,2'b01,1'b0,1'b0,1'b0,32'h20,32'h0,        32'hFFFF_FF44};
        tbl[9]  = '{1'b1,1'b0,2'b01,1'b1,1'b0,1'b0,32'h20,32'h0,        32'h0000_FF44};
        tbl[10] = '{1'b1,1'b0,2'b10,1'b0,1'b0,1'b1,32'h22,32'h0,        32'h1122_FF44};
        tbl[11] = '{1'b1,1'b0,2'b00,1'b1,1'b0,1'b0,32'h23,32'h0,        32'h0000_0011};
        tbl[12] = '{1'b1,1'b1,2'b10,1'b0,1'b0,1'b0,32'h24,32'h0,        32'h0};
        tbl[13] = '{1'b1,1'b1,2'b01,1'b0,1'b0,1'b0,32'h26,32'hABCD_1234,32'h0};
        tbl[14] = '{1'b1,1'b0,2'b11,1'b0,1'b0,1'b0,32'h24,32'h0,        32'h1234_0000};
        tbl[15] = '{1'b1,1'b0,2'b01,1'b0,1'b0,1'b1,32'h21,32'h0,        32'hFFFF_FF44};
        tbl[16] = '{1'b1,1'b1,2'b00,1'b0,1'b0,1'b0,32'h20,32'h0000_0055,32'h0};
        tbl[17] = '{1'b1,1'b0,2'b10,1'b0,1'b1,1'b0,32'h20,32'h0,        32'h1122_FF55};

        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) chk_idle(u, "rst");
        rst_n = '1;

        for (int i = 0; i < 18; i++) access(0, tbl[i], $sformatf("v%0d", i));

        // Wrap on the 16-word instance: 0x40 aliases word 0
        v = '{1'b1,1'b1,2'b10,1'b0,1'b0,1'b0,32'h40,32'hDEAD_BEEF,32'h0};
        access(1, v, "wrap_st");
        v = '{1'b1,1'b0,2'b10,1'b0,1'b0,1'b0,32'h0,32'h0,32'hDEAD_BEEF};
        access(1, v, "wrap_ld");

        // req held for 6 edges with 2 wait states: accepted at edges 0 and 4
        @(posedge clk); #1;
        iord[1] = 1'b1; we[1] = 1'b0; size[1] = 2'b10; irw[1] = 1'b0;
        data_addr[1] = 32'h0; req[1] = 1'b1;
        dpat = '0; bpat = '0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 6) req[1] = 1'b0;
            @(negedge clk);
            dpat[c-1] = done[1];
            bpat[c-1] = busy[1];
        end
        chk("ovl_done", {24'd0, dpat}, 32'h44);
        chk("ovl_busy", {24'd0, bpat}, 32'h77);
        chk("ovl_mdr", mdr[1], 32'hDEAD_BEEF);

        // Reset mid-WAIT aborts a store on the 3-wait instance
        v = '{1'b1,1'b1,2'b10,1'b0,1'b0,1'b0,32'h30,32'h0A0B_0C0D,32'h0};
        access(2, v, "pre_st");
        v = '{1'b1,1'b0,2'b10,1'b0,1'b1,1'b0,32'h30,32'h0,32'h0A0B_0C0D};
        access(2, v, "pre_ld");
        @(posedge clk); #1;
        iord[2] = 1'b1; we[2] = 1'b1; size[2] = 2'b10; wd[2] = 32'hFFFF_FFFF;
        data_addr[2] = 32'h30; req[2] = 1'b1;
        @(posedge clk); #1;
        req[2] = 1'b0;
        @(negedge clk);
        chk("abort_busy_pre", {31'd0, busy[2]}, 32'd1);
        rst_n[2] = 1'b0;
        mdl_mdr[2] = 32'd0;
        mdl_ir[2]  = 32'hCCCC_CCCC;
        #1;
        chk_idle(2, "abort");
        repeat (2) @(posedge clk);
        #1;
        rst_n[2] = 1'b1;
        repeat (5) @(negedge clk);
        chk_idle(2, "post");
        v = '{1'b1,1'b0,2'b10,1'b0,1'b1,1'b0,32'h30,32'h0,32'h0A0B_0C0D};
        access(2, v, "abort_ld");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
